ddr3_axi_ctrl_core: RTL and testbench

AXI4 slave front-end that converts AXI4 read and write bursts into single-beat requests on a simple RAM port, which feeds the DDR3 PHY/controller. One burst is in flight at a time, and at most one RAM read is outstanding. Read data and error status come back as AXI R beats; writes are posted and acknowledged on B.

---
 rtl/ddr3_axi_pkg.sv | 21 ++
 rtl/ddr3_axi_addr_next.sv | 36 +++
 rtl/ddr3_axi_ctrl_core.sv | 219 +++++++++++++++++++++
 tb/tb_ddr3_axi_ctrl_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_pkg.sv
// Shared constants for the DDR3 AXI front-end: burst types, response codes
// and the encoding of the burst-sequencing state machine.
package ddr3_axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_WR_RESP
   } state_e;

endpackage

// File: rtl/ddr3_axi_addr_next.sv
// Next beat address for an AXI burst. The step is one data word; WRAP
// bursts stay inside an aligned block of (len+1) words.
module ddr3_axi_addr_next
   import ddr3_axi_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ADDRS = 32
) (
   input  logic [ADDRS-1:0] addr_i,
   input  logic [1:0]       burst_i,
   input  logic [7:0]       len_i,
   output logic [ADDRS-1:0] next_o
);

   localparam int STEP_SHIFT = $clog2(WIDTH / 8);

   logic [ADDRS-1:0] incrAddr;
   logic [ADDRS-1:0] wrapSize;
   logic [ADDRS-1:0] wrapMask;

   assign incrAddr = addr_i + ADDRS'(WIDTH / 8);
   assign wrapSize = (ADDRS'(len_i) + ADDRS'(1)) << STEP_SHIFT;
   assign wrapMask = wrapSize - ADDRS'(1);

   // Pick the advance rule; reserved burst type behaves like INCR.
   always_comb begin
      next_o = incrAddr;
      case (burst_i)
         BURST_FIXED: next_o = addr_i;
         BURST_WRAP:  next_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
         BURST_INCR:  next_o = incrAddr;
         default:     next_o = incrAddr;
      endcase
   end

endmodule

// File: rtl/ddr3_axi_ctrl_core.sv
// AXI4 slave front-end: turns one read or write burst at a time into
// single-beat RAM requests. Reads keep at most one RAM request in flight;
// writes are posted and acknowledged on B after the last beat.
module ddr3_axi_ctrl_core
   import ddr3_axi_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MASKS = WIDTH / 8,
   parameter int ADDRS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             axi_awvalid_i,
   output logic             axi_awready_o,
   input  logic [ADDRS-1:0] axi_awaddr_i,
   input  logic [3:0]       axi_awid_i,
   input  logic [7:0]       axi_awlen_i,
   input  logic [1:0]       axi_awburst_i,
   input  logic             axi_wvalid_i,
   output logic             axi_wready_o,
   input  logic             axi_wlast_i,
   input  logic [MASKS-1:0] axi_wstrb_i,
   input  logic [WIDTH-1:0] axi_wdata_i,
   output logic             axi_bvalid_o,
   input  logic             axi_bready_i,
   output logic [1:0]       axi_bresp_o,
   output logic [3:0]       axi_bid_o,
   input  logic             axi_arvalid_i,
   output logic             axi_arready_o,
   input  logic [ADDRS-1:0] axi_araddr_i,
   input  logic [3:0]       axi_arid_i,
   input  logic [7:0]       axi_arlen_i,
   input  logic [1:0]       axi_arburst_i,
   output logic             axi_rvalid_o,
   input  logic             axi_rready_i,
   output logic             axi_rlast_o,
   output logic [1:0]       axi_rresp_o,
   output logic [3:0]       axi_rid_o,
   output logic [WIDTH-1:0] axi_rdata_o,
   output logic             ram_wren_o,
   output logic             ram_rden_o,
   output logic [3:0]       ram_req_id_o,
   output logic [ADDRS-1:0] ram_addr_o,
   output logic [MASKS-1:0] ram_wrmask_o,
   output logic [WIDTH-1:0] ram_wrdata_o,
   input  logic             ram_accept_i,
   input  logic             ram_valid_i,
   input  logic             ram_error_i,
   input  logic [3:0]       ram_resp_id_i,
   input  logic [WIDTH-1:0] ram_rddata_i
);

   state_e           state_q,  state_d;
   logic [3:0]       id_q,     id_d;
   logic [ADDRS-1:0] addr_q,   addr_d;
   logic [7:0]       len_q,    len_d;
   logic [1:0]       burst_q,  burst_d;
   logic [7:0]       beat_q,   beat_d;
   logic [WIDTH-1:0] rdData_q, rdData_d;
   logic [1:0]       rdResp_q, rdResp_d;
   logic             wrErr_q,  wrErr_d;

   logic [ADDRS-1:0] nextAddr;
   logic             lastBeat;
   logic             unusedRespId;

   // Responses come back in order with one request outstanding, so the id is not needed.
   assign unusedRespId = ^ram_resp_id_i;

   assign lastBeat    = (beat_q == len_q);
   assign axi_rdata_o = rdData_q;
   assign axi_rresp_o = rdResp_q;

   ddr3_axi_addr_next #(
      .WIDTH (WIDTH),
      .ADDRS (ADDRS)
   ) u_addrNext (
      .addr_i  (addr_q),
      .burst_i (burst_q),
      .len_i   (len_q),
      .next_o  (nextAddr)
   );

   // Register the burst context; an async reset abandons any burst in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         rdData_q <= '0;
         rdResp_q <= '0;
         wrErr_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         rdData_q <= rdData_d;
         rdResp_q <= rdResp_d;
         wrErr_q  <= wrErr_d;
      end
   end

   // Next-state and channel outputs; ready outputs are held low while in reset.
   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      addr_d        = addr_q;
      len_d         = len_q;
      burst_d       = burst_q;
      beat_d        = beat_q;
      rdData_d      = rdData_q;
      rdResp_d      = rdResp_q;
      wrErr_d       = wrErr_q;
      axi_awready_o = 1'b0;
      axi_arready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_bvalid_o  = 1'b0;
      axi_bresp_o   = RESP_OKAY;
      axi_bid_o     = '0;
      axi_rvalid_o  = 1'b0;
      axi_rlast_o   = 1'b0;
      axi_rid_o     = '0;
      ram_wren_o    = 1'b0;
      ram_rden_o    = 1'b0;
      ram_req_id_o  = '0;
      ram_addr_o    = '0;
      ram_wrmask_o  = '0;
      ram_wrdata_o  = '0;
      case (state_q)
         ST_IDLE: begin
            axi_awready_o = reset;
            axi_arready_o = reset & ~axi_awvalid_i;
            if (axi_awvalid_i) begin
               id_d    = axi_awid_i;
               addr_d  = axi_awaddr_i;
               len_d   = axi_awlen_i;
               burst_d = axi_awburst_i;
               beat_d  = '0;
               wrErr_d = 1'b0;
               state_d = ST_WR_DATA;
            end else if (axi_arvalid_i) begin
               id_d    = axi_arid_i;
               addr_d  = axi_araddr_i;
               len_d   = axi_arlen_i;
               burst_d = axi_arburst_i;
               beat_d  = '0;
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            ram_rden_o   = 1'b1;
            ram_addr_o   = addr_q;
            ram_req_id_o = id_q;
            if (ram_accept_i) begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (ram_valid_i) begin
               rdData_d = ram_rddata_i;
               rdResp_d = ram_error_i ? RESP_SLVERR : RESP_OKAY;
               state_d  = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            axi_rvalid_o = 1'b1;
            axi_rid_o    = id_q;
            axi_rlast_o  = lastBeat;
            if (axi_rready_i) begin
               if (lastBeat) begin
                  state_d = ST_IDLE;
               end else begin
                  addr_d  = nextAddr;
                  beat_d  = beat_q + 8'd1;
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_WR_DATA: begin
            axi_wready_o = ram_accept_i;
            ram_wren_o   = axi_wvalid_i;
            ram_wrdata_o = axi_wdata_i;
            ram_wrmask_o = axi_wstrb_i;
            if (axi_wvalid_i) begin
               ram_addr_o   = addr_q;
               ram_req_id_o = id_q;
            end
            if (axi_wvalid_i && ram_accept_i) begin
               addr_d = nextAddr;
               beat_d = beat_q + 8'd1;
               if (ram_error_i) begin
                  wrErr_d = 1'b1;
               end
               if (axi_wlast_i || lastBeat) begin
                  state_d = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            axi_bvalid_o = 1'b1;
            axi_bid_o    = id_q;
            axi_bresp_o  = wrErr_q ? RESP_SLVERR : RESP_OKAY;
            if (axi_bready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ddr3_axi_ctrl_core.sv
// Directed bench for ddr3_axi_ctrl_core: INCR/WRAP/FIXED reads, R back-pressure,
// read and write error reporting, write bursts and an asynchronous reset mid-burst.
module tb_ddr3_axi_ctrl_core;

   localparam int WIDTH = 32;
   localparam int MASKS = 4;
   localparam int ADDRS = 32;

   logic             clock;
   logic             reset;
   logic             axi_awvalid_i;
   logic             axi_awready_o;
   logic [ADDRS-1:0] axi_awaddr_i;
   logic [3:0]       axi_awid_i;
   logic [7:0]       axi_awlen_i;
   logic [1:0]       axi_awburst_i;
   logic             axi_wvalid_i;
   logic             axi_wready_o;
   logic             axi_wlast_i;
   logic [MASKS-1:0] axi_wstrb_i;
   logic [WIDTH-1:0] axi_wdata_i;
   logic             axi_bvalid_o;
   logic             axi_bready_i;
   logic [1:0]       axi_bresp_o;
   logic [3:0]       axi_bid_o;
   logic             axi_arvalid_i;
   logic             axi_arready_o;
   logic [ADDRS-1:0] axi_araddr_i;
   logic [3:0]       axi_arid_i;
   logic [7:0]       axi_arlen_i;
   logic [1:0]       axi_arburst_i;
   logic             axi_rvalid_o;
   logic             axi_rready_i;
   logic             axi_rlast_o;
   logic [1:0]       axi_rresp_o;
   logic [3:0]       axi_rid_o;
   logic [WIDTH-1:0] axi_rdata_o;
   logic             ram_wren_o;
   logic             ram_rden_o;
   logic [3:0]       ram_req_id_o;
   logic [ADDRS-1:0] ram_addr_o;
   logic [MASKS-1:0] ram_wrmask_o;
   logic [WIDTH-1:0] ram_wrdata_o;
   logic             ram_accept_i;
   logic             ram_valid_i;
   logic             ram_error_i;
   logic [3:0]       ram_resp_id_i;
   logic [WIDTH-1:0] ram_rddata_i;

   int compared;
   int mismatched;

   ddr3_axi_ctrl_core #(
      .WIDTH (WIDTH),
      .MASKS (MASKS),
      .ADDRS (ADDRS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .axi_awvalid_i (axi_awvalid_i),
      .axi_awready_o (axi_awready_o),
      .axi_awaddr_i  (axi_awaddr_i),
      .axi_awid_i    (axi_awid_i),
      .axi_awlen_i   (axi_awlen_i),
      .axi_awburst_i (axi_awburst_i),
      .axi_wvalid_i  (axi_wvalid_i),
      .axi_wready_o  (axi_wready_o),
      .axi_wlast_i   (axi_wlast_i),
      .axi_wstrb_i   (axi_wstrb_i),
      .axi_wdata_i   (axi_wdata_i),
      .axi_bvalid_o  (axi_bvalid_o),
      .axi_bready_i  (axi_bready_i),
      .axi_bresp_o   (axi_bresp_o),
      .axi_bid_o     (axi_bid_o),
      .axi_arvalid_i (axi_arvalid_i),
      .axi_arready_o (axi_arready_o),
      .axi_araddr_i  (axi_araddr_i),
      .axi_arid_i    (axi_arid_i),
      .axi_arlen_i   (axi_arlen_i),
      .axi_arburst_i (axi_arburst_i),
      .axi_rvalid_o  (axi_rvalid_o),
      .axi_rready_i  (axi_rready_i),
      .axi_rlast_o   (axi_rlast_o),
      .axi_rresp_o   (axi_rresp_o),
      .axi_rid_o     (axi_rid_o),
      .axi_rdata_o   (axi_rdata_o),
      .ram_wren_o    (ram_wren_o),
      .ram_rden_o    (ram_rden_o),
      .ram_req_id_o  (ram_req_id_o),
      .ram_addr_o    (ram_addr_o),
      .ram_wrmask_o  (ram_wrmask_o),
      .ram_wrdata_o  (ram_wrdata_o),
      .ram_accept_i  (ram_accept_i),
      .ram_valid_i   (ram_valid_i),
      .ram_error_i   (ram_error_i),
      .ram_resp_id_i (ram_resp_id_i),
      .ram_rddata_i  (ram_rddata_i)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] time limit reached");
   end

   // One comparison: count it, and count and report it if it differs.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h required=%0h", tag, observed, expected);
      end
   endtask

   // Present an AR request in IDLE and let it be taken on the next rising edge.
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [3:0] id,
                                input logic [7:0] len, input logic [1:0] burst);
      axi_arvalid_i = 1'b1;
      axi_araddr_i  = addr;
      axi_arid_i    = id;
      axi_arlen_i   = len;
      axi_arburst_i = burst;
      #1;
      checkOutput({tag, "_arready"}, axi_arready_o, 1'b1);
      @(posedge clock);
      @(negedge clock);
      axi_arvalid_i = 1'b0;
   endtask

   // One read beat: RAM request, response one cycle later, R beat with optional back-pressure.
   task automatic readBeat(input string tag, input logic [31:0] expAddr, input logic [3:0] expId,
                           input logic [31:0] data, input logic err, input logic expLast,
                           input int acceptDelay, input int holdCycles);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ram_rden_o === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      checkOutput({tag, "_rden"}, found, 1'b1);
      checkOutput({tag, "_addr"}, ram_addr_o, expAddr);
      checkOutput({tag, "_reqid"}, ram_req_id_o, expId);
      if (acceptDelay > 0) begin
         ram_accept_i = 1'b0;
         repeat (acceptDelay) @(negedge clock);
         checkOutput({tag, "_heldReq"}, {ram_rden_o, ram_addr_o}, {1'b1, expAddr});
         ram_accept_i = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      checkOutput({tag, "_rdenDrop"}, ram_rden_o, 1'b0);
      ram_valid_i  = 1'b1;
      ram_rddata_i = data;
      ram_error_i  = err;
      @(posedge clock);
      @(negedge clock);
      ram_valid_i  = 1'b0;
      ram_error_i  = 1'b0;
      ram_rddata_i = '0;
      checkOutput({tag, "_rvalid"}, axi_rvalid_o, 1'b1);
      checkOutput({tag, "_rdata"}, axi_rdata_o, data);
      checkOutput({tag, "_rresp"}, axi_rresp_o, err ? 2'b10 : 2'b00);
      checkOutput({tag, "_rid"}, axi_rid_o, expId);
      checkOutput({tag, "_rlast"}, axi_rlast_o, expLast);
      if (holdCycles > 0) begin
         repeat (holdCycles) @(negedge clock);
         checkOutput({tag, "_holdStable"}, {axi_rvalid_o, axi_rlast_o, axi_rresp_o, axi_rdata_o},
                     {1'b1, expLast, err ? 2'b10 : 2'b00, data});
         checkOutput({tag, "_holdNoRden"}, ram_rden_o, 1'b0);
      end
      axi_rready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      axi_rready_i = 1'b0;
   endtask

   // Directed sequence of read, write and reset scenarios.
   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b0;
      axi_awvalid_i = 1'b0;
      axi_awaddr_i  = '0;
      axi_awid_i    = '0;
      axi_awlen_i   = '0;
      axi_awburst_i = '0;
      axi_wvalid_i  = 1'b0;
      axi_wlast_i   = 1'b0;
      axi_wstrb_i   = '0;
      axi_wdata_i   = '0;
      axi_bready_i  = 1'b0;
      axi_arvalid_i = 1'b0;
      axi_araddr_i  = '0;
      axi_arid_i    = '0;
      axi_arlen_i   = '0;
      axi_arburst_i = '0;
      axi_rready_i  = 1'b0;
      ram_accept_i  = 1'b1;
      ram_valid_i   = 1'b0;
      ram_error_i   = 1'b0;
      ram_resp_id_i = '0;
      ram_rddata_i  = '0;

      #2;
      checkOutput("resetReady", {axi_awready_o, axi_arready_o, axi_wready_o}, 3'b000);
      checkOutput("resetResp", {axi_bvalid_o, axi_rvalid_o, axi_rlast_o, axi_rresp_o, axi_rdata_o}, '0);
      checkOutput("resetRam", {ram_wren_o, ram_rden_o, ram_req_id_o, ram_addr_o}, '0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("idleReady", {axi_awready_o, axi_arready_o}, 2'b11);
      @(negedge clock);

      $display("[TB] INCR read, len 3, with back-pressure on beat 2");
      applyStimulus("incr", 32'h0, 4'd1, 8'd3, 2'b01);
      readBeat("incrB0", 32'h0, 4'd1, 32'h1111_1111, 1'b0, 1'b0, 0, 0);
      readBeat("incrB1", 32'h4, 4'd1, 32'h2222_2222, 1'b0, 1'b0, 0, 5);
      readBeat("incrB2", 32'h8, 4'd1, 32'h3333_3333, 1'b0, 1'b0, 0, 0);
      readBeat("incrB3", 32'hC, 4'd1, 32'h4444_4444, 1'b0, 1'b1, 0, 0);
      checkOutput("incrDone", {axi_rvalid_o, axi_arready_o}, 2'b01);

      $display("[TB] WRAP read from 8, len 3");
      applyStimulus("wrap", 32'h8, 4'd2, 8'd3, 2'b10);
      readBeat("wrapB0", 32'h8, 4'd2, 32'hA0A0_0001, 1'b0, 1'b0, 2, 0);
      readBeat("wrapB1", 32'hC, 4'd2, 32'hA0A0_0002, 1'b0, 1'b0, 0, 0);
      readBeat("wrapB2", 32'h0, 4'd2, 32'hA0A0_0003, 1'b0, 1'b0, 0, 0);
      readBeat("wrapB3", 32'h4, 4'd2, 32'hA0A0_0004, 1'b0, 1'b1, 0, 0);

      $display("[TB] INCR read with RAM error on the middle beat");
      applyStimulus("err", 32'h200, 4'd3, 8'd2, 2'b01);
      readBeat("errB0", 32'h200, 4'd3, 32'hBEEF_0000, 1'b0, 1'b0, 0, 0);
      readBeat("errB1", 32'h204, 4'd3, 32'hBEEF_0001, 1'b1, 1'b0, 0, 0);
      readBeat("errB2", 32'h208, 4'd3, 32'hBEEF_0002, 1'b0, 1'b1, 0, 0);

      $display("[TB] FIXED read, len 1");
      applyStimulus("fixed", 32'h20, 4'd4, 8'd1, 2'b00);
      readBeat("fixedB0", 32'h20, 4'd4, 32'h5555_AAAA, 1'b0, 1'b0, 0, 0);
      readBeat("fixedB1", 32'h20, 4'd4, 32'hAAAA_5555, 1'b0, 1'b1, 0, 0);

      $display("[TB] INCR write at 0x100, len 1, AW and AR together");
      axi_awvalid_i = 1'b1;
      axi_awaddr_i  = 32'h100;
      axi_awid_i    = 4'd5;
      axi_awlen_i   = 8'd1;
      axi_awburst_i = 2'b01;
      axi_arvalid_i = 1'b1;
      axi_araddr_i  = 32'h300;
      #1;
      checkOutput("wrWins", {axi_awready_o, axi_arready_o}, 2'b10);
      @(posedge clock);
      @(negedge clock);
      axi_awvalid_i = 1'b0;
      axi_arvalid_i = 1'b0;
      axi_wvalid_i  = 1'b1;
      axi_wdata_i   = 32'hDEAD_BEEF;
      axi_wstrb_i   = 4'hF;
      axi_wlast_i   = 1'b0;
      #1;
      checkOutput("wrB0", {axi_wready_o, ram_wren_o, ram_rden_o, ram_addr_o, ram_wrmask_o, ram_wrdata_o},
                  {1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'hDEAD_BEEF});
      @(posedge clock);
      @(negedge clock);
      axi_wdata_i = 32'h0000_1234;
      axi_wstrb_i = 4'h3;
      axi_wlast_i = 1'b1;
      #1;
      checkOutput("wrB1", {ram_wren_o, ram_req_id_o, ram_addr_o, ram_wrmask_o, ram_wrdata_o},
                  {1'b1, 4'd5, 32'h104, 4'h3, 32'h0000_1234});
      @(posedge clock);
      @(negedge clock);
      axi_wvalid_i = 1'b0;
      axi_wlast_i  = 1'b0;
      #1;
      checkOutput("wrResp", {axi_bvalid_o, axi_bid_o, axi_bresp_o, ram_wren_o}, {1'b1, 4'd5, 2'b00, 1'b0});
      axi_bready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      axi_bready_i = 1'b0;
      #1;
      checkOutput("wrDone", {axi_bvalid_o, axi_awready_o}, 2'b01);

      $display("[TB] single-beat write ending on len without wlast, RAM error");
      @(negedge clock);
      axi_awvalid_i = 1'b1;
      axi_awaddr_i  = 32'h40;
      axi_awid_i    = 4'd9;
      axi_awlen_i   = 8'd0;
      @(posedge clock);
      @(negedge clock);
      axi_awvalid_i = 1'b0;
      axi_wvalid_i  = 1'b1;
      axi_wdata_i   = 32'h0BAD_0BAD;
      axi_wstrb_i   = 4'h1;
      ram_error_i   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      axi_wvalid_i = 1'b0;
      ram_error_i  = 1'b0;
      #1;
      checkOutput("wrErrResp", {axi_bvalid_o, axi_bid_o, axi_bresp_o}, {1'b1, 4'd9, 2'b10});
      axi_bready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      axi_bready_i = 1'b0;

      $display("[TB] reset asserted mid read burst");
      applyStimulus("rst", 32'h40, 4'd6, 8'd3, 2'b01);
      @(posedge clock);
      @(negedge clock);
      ram_valid_i  = 1'b1;
      ram_rddata_i = 32'hCAFE_F00D;
      @(posedge clock);
      @(negedge clock);
      ram_valid_i  = 1'b0;
      ram_rddata_i = '0;
      checkOutput("rstPre", {axi_rvalid_o, axi_rdata_o}, {1'b1, 32'hCAFE_F00D});
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstR", {axi_rvalid_o, axi_rlast_o, axi_rresp_o, axi_rid_o, axi_rdata_o}, '0);
      checkOutput("rstReady", {axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o}, 4'b0000);
      checkOutput("rstRam", {ram_wren_o, ram_rden_o, ram_req_id_o, ram_addr_o}, '0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("rstIdle", {axi_awready_o, axi_arready_o, axi_rvalid_o}, 3'b110);
      @(negedge clock);
      applyStimulus("post", 32'h80, 4'd7, 8'd0, 2'b01);
      readBeat("postB0", 32'h80, 4'd7, 32'h7777_0080, 1'b0, 1'b1, 0, 0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
